// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_pkg
// Purpose  : Shared definitions for the segmented pipelined adder/subtractor.
//            Provides the add/subtract mode encoding and the helpers used to
//            derive and sanity-check the slice count.
// Contents : ADD / SUB mode constants, calc_nseg(), width_ok()
// Revision : 1.0 - initial release
// ============================================================================
package pipe_adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Number of SEG_W-bit slices (and hence pipeline stages) in a WIDTH-bit add.
  function automatic int calc_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // WIDTH must split into a whole number of non-empty slices.
  function automatic bit width_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_adder_seg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_seg
// Purpose  : One SEG_W-bit slice of the pipelined adder. Adds a, b and the
//            incoming carry, and registers the slice sum and carry-out.
//            Registers advance only when en is high.
// Ports    : clk, rst (async, active-high), en (advance enable),
//            a, b [SEG_W] slice operands, ci carry-in,
//            sum [SEG_W] registered slice sum, co registered carry-out
// Revision : 1.0 - initial release
// ============================================================================
module pipe_adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] sum,
  output logic             co
);

  logic [SEG_W:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, ci};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      co  <= 1'b0;
    end else if (en) begin
      sum <= total[SEG_W-1:0];
      co  <= total[SEG_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Purpose  : Segmented pipelined adder/subtractor with valid/ready handshake.
//            A WIDTH-bit operation is split into NSEG = WIDTH/SEG_W slices,
//            one per stage, with the carry rippling stage to stage. Upper
//            operand slices are skewed in, finished lower sum slices are
//            deskewed out, so the output register holds a coherent result
//            NSEG edges after the accepting edge.
//            sub=0: {cout,sum} = a + b + cin
//            sub=1: {cout,sum} = a + ~b + !cin  (cout = not-borrow)
// Ports    : clk, rst (async, active-high)
//            in_valid, in_ready, a, b, cin, sub   - input transaction
//            out_valid, out_ready, sum, cout      - output transaction
//            ovf                                  - only with PIPE_ADDER_OVF_EN
// Config   : define PIPE_ADDER_OVF_EN to add the registered signed-overflow
//            flag output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  if (!width_ok(WIDTH, SEG_W)) begin : g_width_check
    $error("pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             en;
  logic [WIDTH-1:0] b_cond;
  logic             cin_cond;
  logic [NSEG-1:0]  stage_valid;
  logic [NSEG-1:0]  stage_ci;
  logic [NSEG-1:0]  stage_co;
  logic [SEG_W-1:0] stage_a   [NSEG];
  logic [SEG_W-1:0] stage_b   [NSEG];
  logic [SEG_W-1:0] stage_sum [NSEG];
  logic [WIDTH-1:0] sum_next;

  // The whole pipe moves as one; it only stalls when a finished result is
  // waiting and downstream refuses it.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtraction is a + ~b + !cin, so the conditioning happens once on entry
  // and each slice is a plain adder.
  assign b_cond   = (sub == ADD) ? b : ~b;
  assign cin_cond = (sub == SUB) ? ~cin : cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      out_valid   <= 1'b0;
    end else if (en) begin
      stage_valid[0] <= in_valid;
      for (int k = 1; k < NSEG; k++) begin
        stage_valid[k] <= stage_valid[k-1];
      end
      out_valid <= stage_valid[NSEG-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_slice
    if (k == 0) begin : g_first
      assign stage_a[0]  = a[SEG_W-1:0];
      assign stage_b[0]  = b_cond[SEG_W-1:0];
      assign stage_ci[0] = cin_cond;
    end else begin : g_skew
      // Slice k must wait k cycles so it meets the carry from slice k-1.
      logic [2*SEG_W-1:0] skew [k];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            skew[i] <= '0;
          end
        end else if (en) begin
          skew[0] <= {a[k*SEG_W +: SEG_W], b_cond[k*SEG_W +: SEG_W]};
          for (int i = 1; i < k; i++) begin
            skew[i] <= skew[i-1];
          end
        end
      end

      assign stage_a[k]  = skew[k-1][2*SEG_W-1:SEG_W];
      assign stage_b[k]  = skew[k-1][SEG_W-1:0];
      assign stage_ci[k] = stage_co[k-1];
    end

    pipe_adder_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (stage_a[k]),
      .b   (stage_b[k]),
      .ci  (stage_ci[k]),
      .sum (stage_sum[k]),
      .co  (stage_co[k])
    );

    if (k < NSEG - 1) begin : g_deskew
      // Slice k finishes NSEG-1-k cycles before the top slice; hold it back.
      localparam int DEPTH = NSEG - 1 - k;
      logic [SEG_W-1:0] dsk [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            dsk[i] <= '0;
          end
        end else if (en) begin
          dsk[0] <= stage_sum[k];
          for (int i = 1; i < DEPTH; i++) begin
            dsk[i] <= dsk[i-1];
          end
        end
      end

      assign sum_next[k*SEG_W +: SEG_W] = dsk[DEPTH-1];
    end else begin : g_top
      assign sum_next[k*SEG_W +: SEG_W] = stage_sum[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= sum_next;
      cout <= stage_co[NSEG-1];
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  // Operand sign bits captured alongside the top slice. With b already
  // conditioned, one rule covers both modes: equal operand signs and a
  // result sign different from a.
  logic a_msb_q;
  logic b_msb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf     <= 1'b0;
    end else if (en) begin
      a_msb_q <= stage_a[NSEG-1][SEG_W-1];
      b_msb_q <= stage_b[NSEG-1][SEG_W-1];
      ovf     <= (a_msb_q == b_msb_q) && (stage_sum[NSEG-1][SEG_W-1] != a_msb_q);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder
// Purpose  : Self-checking bench for pipe_adder. Three instances: 32/8 main,
//            8/8 and 64/16 parameter sweeps. Stimulus pushes expected results
//            into per-instance queues; monitors pop and compare on transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- main instance: WIDTH=32, SEG_W=8 ----------------
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  pipe_adder #(.WIDTH(32), .SEG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
`ifndef PIPE_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  // ---------------- sweep instance: WIDTH=8, SEG_W=8 ----------------
  logic       in_valid8, in_ready8, out_valid8, cout8, ovf8;
  logic       out_ready8 = 1'b1;
  logic [7:0] a8, b8, sum8;

  pipe_adder #(.WIDTH(8), .SEG_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );
`ifndef PIPE_ADDER_OVF_EN
  assign ovf8 = 1'b0;
`endif

  // ---------------- sweep instance: WIDTH=64, SEG_W=16 ----------------
  logic        in_valid64, in_ready64, cin64, sub64, out_valid64, cout64, ovf64;
  logic        out_ready64 = 1'b1;
  logic [63:0] a64, b64, sum64;

  pipe_adder #(.WIDTH(64), .SEG_W(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .cin(cin64), .sub(sub64),
    .out_valid(out_valid64), .out_ready(out_ready64), .sum(sum64), .cout(cout64)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf64)
`endif
  );
`ifndef PIPE_ADDER_OVF_EN
  assign ovf64 = 1'b0;
`endif

  // ---------------- reference helpers ----------------
  function automatic logic ovf_ref(input logic [31:0] av, bv, input logic sv, input logic [31:0] s);
    if (!sv) return (av[31] == bv[31]) && (s[31] != av[31]);
    else     return (av[31] != bv[31]) && (s[31] != av[31]);
  endfunction

  function automatic logic [64:0] ref64(input logic [63:0] av, bv, input logic cv, sv);
    logic [64:0] r;
    if (!sv) r = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
    else begin
      r[63:0] = av - bv - {63'd0, cv};
      r[64]   = ({1'b0, av} >= ({1'b0, bv} + {64'd0, cv}));
    end
    return r;
  endfunction

  // ---------------- scoreboards and monitors ----------------
  logic [33:0] q32[$];
  logic [8:0]  q8[$];
  logic [64:0] q64[$];
  logic [33:0] e32;
  logic [8:0]  e8;
  logic [64:0] e64;
  bit          stalled = 1'b0;
  logic [33:0] held;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_result", {ovf, cout, sum}, held);
      end
      if (out_valid && out_ready) begin
        if (q32.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out32: got sum %0h, expected no output", sum);
        end else begin
          e32 = q32.pop_front();
          chk("sum32", sum, e32[31:0]);
          chk("cout32", cout, e32[32]);
`ifdef PIPE_ADDER_OVF_EN
          chk("ovf32", ovf, e32[33]);
`endif
        end
      end
      stalled = out_valid && !out_ready;
      held    = {ovf, cout, sum};
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out8: got sum %0h, expected no output", sum8);
      end else begin
        e8 = q8.pop_front();
        chk("result8", {cout8, sum8}, e8);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid64) begin
      if (q64.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out64: got sum %0h, expected no output", sum64);
      end else begin
        e64 = q64.pop_front();
        chk("result64", {cout64, sum64}, e64);
      end
    end
  end

  // ---------------- drivers (entered at posedge+#1) ----------------
  task automatic send32(input logic [31:0] av, bv, input logic cv, sv,
                        input logic [31:0] es, input logic ec);
    bit ok = 1'b0;
    int n  = 0;
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) q32.push_back({ovf_ref(av, bv, sv, es), ec, es});
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept32_timeout: in_ready got 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic send64(input logic [63:0] av, bv, input logic cv, sv);
    bit ok = 1'b0;
    int n  = 0;
    a64 = av; b64 = bv; cin64 = cv; sub64 = sv; in_valid64 = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready64;
      if (ok) q64.push_back(ref64(av, bv, cv, sv));
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept64_timeout: in_ready got 0 expected 1");
    end
    in_valid64 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          lat;
    int          n;
    int          seen;
    logic [31:0] iv;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
    in_valid64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_sum", sum, 32'h0);
    chk("reset_cout", cout, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full carry ripple across all four slices, with latency measurement.
    send32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency32", lat, 4);

    // Subtraction with borrow and without.
    send32(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    send32(32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    // Eight back-to-back transfers with a 3-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          iv = i;
          send32(iv, iv * 32'h10, iv[0], 1'b0, iv * 32'h11 + {31'd0, iv[0]}, 1'b0);
        end
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1'b0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("drain32_stall", q32.size(), 0);

`ifdef PIPE_ADDER_OVF_EN
    send32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
    send32(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
    repeat (8) @(posedge clk);
    #1;
`endif

    // Reset with one stalled result at the output and three in flight.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      iv = i;
      send32(iv, 32'h100, 1'b0, 1'b0, iv + 32'h100, 1'b0);
    end
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_sum", sum, 32'h0);
    chk("async_rst_cout", cout, 1'b0);
`ifdef PIPE_ADDER_OVF_EN
    chk("async_rst_ovf", ovf, 1'b0);
`endif
    q32.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("no_stale_after_rst", seen, 0);
    send32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency32_after_rst", lat, 4);
    repeat (4) @(posedge clk);
    #1;

    // WIDTH=8: single stage, latency 1.
    a8 = 8'hFF; b8 = 8'h01; in_valid8 = 1'b1;
    @(negedge clk);
    chk("ready8", in_ready8, 1'b1);
    q8.push_back({1'b1, 8'h00});
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency8", lat, 1);
    repeat (3) @(posedge clk);
    #1;

    // WIDTH=64, SEG_W=16: latency 4, then random back-to-back traffic.
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    lat = 0;
    while (!out_valid64 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency64", lat, 4);
    for (int i = 0; i < 12; i++) begin
      send64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    repeat (10) @(posedge clk);
    #1;

    chk("drain32", q32.size(), 0);
    chk("drain8", q8.size(), 0);
    chk("drain64", q64.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
